// File: rtl/uart_frame_receiver_pkg.sv
// Shared FSM states, error codes and defaults for the framed UART receiver.
package uart_frame_receiver_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2,
    ST_COMMIT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_CHECKSUM = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 byte receiver, LSB first, CLKS_PER_BIT clocks per bit, no reset port.
// o_Rx_DV pulses one cycle at mid stop bit; bytes with a low stop bit are dropped.
module uart_rx
  import uart_frame_receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       i_Clock,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

  logic             r_sync1;
  logic             r_sync2;
  rx_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_byte;
  logic             r_dv;

  always_ff @(posedge i_Clock) begin
    r_sync1 <= i_Rx_Serial;
    r_sync2 <= r_sync1;
    r_dv    <= 1'b0;
    case (r_state)
      RX_IDLE: begin
        r_cnt <= '0;
        r_bit <= '0;
        if (!r_sync2) r_state <= RX_START;
      end
      // Re-check at mid start bit so a glitch does not launch a byte.
      RX_START: begin
        if (r_cnt == HALF_BIT) begin
          r_cnt   <= '0;
          r_state <= r_sync2 ? RX_IDLE : RX_DATA;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (r_cnt == FULL_BIT) begin
          r_cnt         <= '0;
          r_byte[r_bit] <= r_sync2;
          if (r_bit == 3'd7) r_state <= RX_STOP;
          else               r_bit   <= r_bit + 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (r_cnt == FULL_BIT) begin
          r_dv    <= r_sync2;
          r_state <= RX_IDLE;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      default: r_state <= RX_IDLE;
    endcase
  end

  assign o_Rx_DV   = r_dv;
  assign o_Rx_Byte = r_byte;

endmodule

// File: rtl/uart_frame_receiver.sv
// Assembles SYNC-delimited, optionally checksummed UART frames into one flat word bus.
// Only complete, verified frames reach o_data; discards pulse o_frame_err with a held cause.
module uart_frame_receiver
  import uart_frame_receiver_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         WORD_BYTES   = 2,
  parameter int         NUM_WORDS    = 4,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
  parameter int         USE_CHECKSUM = 1,
  parameter int         TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_serial_in,
  output logic [NUM_WORDS*WORD_BYTES*8-1:0] o_data,
  output logic                              o_data_valid,
  output logic                              o_frame_err,
  output logic [1:0]                        o_err_code,
  output logic [7:0]                        o_frame_count
);

  localparam int P     = NUM_WORDS * WORD_BYTES;
  localparam int DW    = P * 8;
  localparam int IDX_W = (P > 1) ? $clog2(P) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(P - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CLKS);

  logic            w_rx_dv;
  logic [7:0]      w_rx_byte;
  logic [DW-1:0]   w_shadow_next;
  logic            w_is_sync;
  logic            w_timeout;

  state_t          r_state;
  logic [IDX_W-1:0] r_byte_idx;
  logic [7:0]      r_sum;
  logic [TO_W-1:0] r_idle;
  logic [DW-1:0]   r_shadow;
  logic [DW-1:0]   r_data;
  logic            r_data_valid;
  logic            r_frame_err;
  logic [1:0]      r_err_code;
  logic [7:0]      r_frame_count;

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_rx (
    .i_Clock     (i_clk),
    .i_Rx_Serial (i_serial_in),
    .o_Rx_DV     (w_rx_dv),
    .o_Rx_Byte   (w_rx_byte)
  );

  // Byte 0 lands in the most significant byte lane.
  always_comb begin
    w_shadow_next = r_shadow;
    for (int i = 0; i < P; i++) begin
      if (r_byte_idx == IDX_W'(i)) w_shadow_next[(P-1-i)*8 +: 8] = w_rx_byte;
    end
  end

  assign w_is_sync = w_rx_dv && (w_rx_byte == SYNC_BYTE);
  assign w_timeout = (r_idle == TO_LIMIT);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= ST_HUNT;
      r_byte_idx    <= '0;
      r_sum         <= '0;
      r_idle        <= '0;
      r_shadow      <= '0;
      r_data        <= '0;
      r_data_valid  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_err_code    <= ERR_NONE;
      r_frame_count <= '0;
    end else begin
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        // A byte arriving on the expiry cycle still counts.
        ST_PAYLOAD: begin
          if (w_rx_dv) begin
            r_shadow   <= w_shadow_next;
            r_sum      <= sum8(r_sum, w_rx_byte);
            r_idle     <= '0;
            r_byte_idx <= r_byte_idx + 1'b1;
            if (r_byte_idx == LAST_IDX) begin
              if (USE_CHECKSUM != 0) begin
                r_state <= ST_CHECK;
              end else begin
                r_data        <= w_shadow_next;
                r_data_valid  <= 1'b1;
                r_frame_count <= r_frame_count + 1'b1;
                r_state       <= ST_COMMIT;
              end
            end
          end else if (w_timeout) begin
            r_frame_err <= 1'b1;
            r_err_code  <= ERR_TIMEOUT;
            r_state     <= ST_HUNT;
          end else begin
            r_idle <= r_idle + 1'b1;
          end
        end
        ST_CHECK: begin
          if (w_rx_dv) begin
            r_idle <= '0;
            if (w_rx_byte == r_sum) begin
              r_data        <= r_shadow;
              r_data_valid  <= 1'b1;
              r_frame_count <= r_frame_count + 1'b1;
              r_state       <= ST_COMMIT;
            end else begin
              r_frame_err <= 1'b1;
              r_err_code  <= ERR_CHECKSUM;
              r_state     <= ST_HUNT;
            end
          end else if (w_timeout) begin
            r_frame_err <= 1'b1;
            r_err_code  <= ERR_TIMEOUT;
            r_state     <= ST_HUNT;
          end else begin
            r_idle <= r_idle + 1'b1;
          end
        end
        // HUNT and COMMIT: a stray byte during COMMIT is treated as hunting.
        default: begin
          r_state <= ST_HUNT;
          if (w_is_sync) begin
            r_state    <= ST_PAYLOAD;
            r_byte_idx <= '0;
            r_sum      <= '0;
            r_idle     <= '0;
          end
        end
      endcase
    end
  end

  assign o_data        = r_data;
  assign o_data_valid  = r_data_valid;
  assign o_frame_err   = r_frame_err;
  assign o_err_code    = r_err_code;
  assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Bench for uart_frame_receiver: serial frames built from payload words, outcomes predicted
// from the framing rules (sum-of-payload checksum, byte 0 in MS bits, idle timeout).
module tb_uart_frame_receiver;

  localparam int         CPB  = 4;
  localparam int         WB   = 2;
  localparam int         NW   = 2;
  localparam int         P    = WB * NW;
  localparam int         DW   = P * 8;
  localparam int         TO   = 20 * CPB;
  localparam logic [7:0] SYNC = 8'hA5;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          serial = 1'b1;
  logic [DW-1:0] data;
  logic          dv;
  logic          fe;
  logic [1:0]    ec;
  logic [7:0]    fc;

  int n_assert = 0;
  int n_fail   = 0;

  int cyc            = 0;
  int n_valid        = 0;
  int n_err          = 0;
  int last_valid_cyc = 0;
  int stop_cyc       = 0;
  bit both_seen      = 1'b0;

  logic [7:0]    exp_count = 8'd0;
  logic [DW-1:0] exp_data  = '0;
  logic [1:0]    exp_ec    = 2'd0;

  always #5 clk = ~clk;

  uart_frame_receiver #(
    .CLKS_PER_BIT (CPB),
    .WORD_BYTES   (WB),
    .NUM_WORDS    (NW),
    .SYNC_BYTE    (SYNC),
    .USE_CHECKSUM (1),
    .TIMEOUT_CLKS (TO)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_serial_in   (serial),
    .o_data        (data),
    .o_data_valid  (dv),
    .o_frame_err   (fe),
    .o_err_code    (ec),
    .o_frame_count (fc)
  );

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (dv) begin
      n_valid        <= n_valid + 1;
      last_valid_cyc <= cyc;
    end
    if (fe) n_err <= n_err + 1;
    if (dv && fe) both_seen <= 1'b1;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not complete, got time %0t required below 1500000", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] model_csum(input logic [DW-1:0] pl);
    int s;
    s = 0;
    for (int i = 0; i < P; i++) s += int'(pl[DW-1-8*i -: 8]);
    return 8'(s % 256);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      serial = bits[i];
      if (i == 9) stop_cyc = cyc;
      repeat (CPB - 1) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] pl, input logic [7:0] cs_xor);
    send_byte(SYNC);
    for (int i = 0; i < P; i++) send_byte(pl[DW-1-8*i -: 8]);
    send_byte(model_csum(pl) ^ cs_xor);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_assert++; if (data !== '0)   begin n_fail++; $display("FAIL reset_data: got %h expected 0", data); end
    n_assert++; if (dv !== 1'b0)   begin n_fail++; $display("FAIL reset_valid: got %b expected 0", dv); end
    n_assert++; if (fe !== 1'b0)   begin n_fail++; $display("FAIL reset_err: got %b expected 0", fe); end
    n_assert++; if (ec !== 2'd0)   begin n_fail++; $display("FAIL reset_code: got %0d expected 0", ec); end
    n_assert++; if (fc !== 8'd0)   begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fc); end
    rst_n = 1'b1;
    idle(500);
    n_assert++; if (n_valid != 0)  begin n_fail++; $display("FAIL idle_valid: got %0d pulses expected 0", n_valid); end
    n_assert++; if (n_err != 0)    begin n_fail++; $display("FAIL idle_err: got %0d pulses expected 0", n_err); end
  endtask

  task automatic test_good_frame;
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    send_frame(32'h12345678, 8'h00);
    idle(4);
    exp_data = 32'h12345678; exp_count++;
    n_assert++; if (n_valid != v0 + 1) begin n_fail++; $display("FAIL good_pulses: got %0d expected %0d", n_valid - v0, 1); end
    n_assert++; if (n_err != e0)       begin n_fail++; $display("FAIL good_errs: got %0d expected 0", n_err - e0); end
    n_assert++; if (data !== exp_data) begin n_fail++; $display("FAIL good_data: got %h expected %h", data, exp_data); end
    n_assert++; if (fc !== exp_count)  begin n_fail++; $display("FAIL good_count: got %0d expected %0d", fc, exp_count); end
    n_assert++;
    if ((last_valid_cyc - stop_cyc) < 4 || (last_valid_cyc - stop_cyc) > 7) begin
      n_fail++; $display("FAIL good_latency: got %0d cycles after stop bit expected 4..7", last_valid_cyc - stop_cyc);
    end
  endtask

  task automatic test_checksum_error;
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    send_frame(32'h12345678, 8'h01);
    idle(4);
    exp_ec = 2'd1;
    n_assert++; if (n_err != e0 + 1)   begin n_fail++; $display("FAIL csum_errs: got %0d expected 1", n_err - e0); end
    n_assert++; if (n_valid != v0)     begin n_fail++; $display("FAIL csum_pulses: got %0d expected 0", n_valid - v0); end
    n_assert++; if (ec !== exp_ec)     begin n_fail++; $display("FAIL csum_code: got %0d expected %0d", ec, exp_ec); end
    n_assert++; if (data !== exp_data) begin n_fail++; $display("FAIL csum_data: got %h expected %h", data, exp_data); end
    n_assert++; if (fc !== exp_count)  begin n_fail++; $display("FAIL csum_count: got %0d expected %0d", fc, exp_count); end
  endtask

  task automatic test_sync_in_payload;
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_frame(32'hA5010203, 8'h00);
    idle(4);
    exp_data = 32'hA5010203; exp_count++;
    n_assert++; if (n_valid != v0 + 1) begin n_fail++; $display("FAIL sync_pulses: got %0d expected 1", n_valid - v0); end
    n_assert++; if (n_err != e0)       begin n_fail++; $display("FAIL sync_errs: got %0d expected 0", n_err - e0); end
    n_assert++; if (data !== exp_data) begin n_fail++; $display("FAIL sync_data: got %h expected %h", data, exp_data); end
    n_assert++; if (fc !== exp_count)  begin n_fail++; $display("FAIL sync_count: got %0d expected %0d", fc, exp_count); end
    n_assert++; if (ec !== exp_ec)     begin n_fail++; $display("FAIL sync_code_held: got %0d expected %0d", ec, exp_ec); end
  endtask

  task automatic test_timeout;
    int v0, e0;
    logic [DW-1:0] pl;
    v0 = n_valid; e0 = n_err;
    send_byte(SYNC);
    send_byte(8'h12);
    idle(TO + 40);
    exp_ec = 2'd2;
    n_assert++; if (n_err != e0 + 1)   begin n_fail++; $display("FAIL to_errs: got %0d expected 1", n_err - e0); end
    n_assert++; if (ec !== exp_ec)     begin n_fail++; $display("FAIL to_code: got %0d expected %0d", ec, exp_ec); end
    n_assert++; if (data !== exp_data) begin n_fail++; $display("FAIL to_data: got %h expected %h", data, exp_data); end
    n_assert++; if (n_valid != v0)     begin n_fail++; $display("FAIL to_pulses: got %0d expected 0", n_valid - v0); end
    pl = DW'($urandom());
    send_frame(pl, 8'h00);
    idle(4);
    exp_data = pl; exp_count++;
    n_assert++; if (data !== exp_data) begin n_fail++; $display("FAIL to_next_data: got %h expected %h", data, exp_data); end
    n_assert++; if (fc !== exp_count)  begin n_fail++; $display("FAIL to_next_count: got %0d expected %0d", fc, exp_count); end
  endtask

  task automatic test_random_frames;
    int v0, e0, nn;
    bit bad;
    logic [DW-1:0] pl;
    logic [7:0] nb;
    for (int it = 0; it < 15; it++) begin
      v0 = n_valid; e0 = n_err;
      nn = $urandom_range(0, 2);
      for (int k = 0; k < nn; k++) begin
        nb = 8'($urandom_range(0, 255));
        if (nb == SYNC) nb = 8'h00;
        send_byte(nb);
      end
      pl  = DW'($urandom());
      bad = ($urandom_range(0, 3) == 0);
      send_frame(pl, bad ? 8'($urandom_range(1, 255)) : 8'h00);
      idle(4);
      if (bad) exp_ec = 2'd1;
      else begin exp_data = pl; exp_count++; end
      n_assert++; if (n_valid != v0 + (bad ? 0 : 1)) begin n_fail++; $display("FAIL rnd_pulses[%0d]: got %0d expected %0d", it, n_valid - v0, bad ? 0 : 1); end
      n_assert++; if (n_err != e0 + (bad ? 1 : 0))   begin n_fail++; $display("FAIL rnd_errs[%0d]: got %0d expected %0d", it, n_err - e0, bad ? 1 : 0); end
      n_assert++; if (data !== exp_data) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h expected %h", it, data, exp_data); end
      n_assert++; if (fc !== exp_count)  begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", it, fc, exp_count); end
      n_assert++; if (ec !== exp_ec)     begin n_fail++; $display("FAIL rnd_code[%0d]: got %0d expected %0d", it, ec, exp_ec); end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [DW-1:0] pl;
    send_byte(SYNC);
    send_byte(8'($urandom_range(0, 255)));
    send_byte(8'($urandom_range(0, 255)));
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    exp_data = '0; exp_count = 8'd0; exp_ec = 2'd0;
    n_assert++; if (data !== exp_data) begin n_fail++; $display("FAIL midrst_data: got %h expected 0", data); end
    n_assert++; if (fc !== exp_count)  begin n_fail++; $display("FAIL midrst_count: got %0d expected 0", fc); end
    n_assert++; if (ec !== exp_ec)     begin n_fail++; $display("FAIL midrst_code: got %0d expected 0", ec); end
    rst_n = 1'b1;
    idle(20);
    pl = DW'($urandom());
    send_frame(pl, 8'h00);
    idle(4);
    exp_data = pl; exp_count++;
    n_assert++; if (fc !== exp_count)  begin n_fail++; $display("FAIL midrst_next_count: got %0d expected %0d", fc, exp_count); end
    n_assert++; if (data !== exp_data) begin n_fail++; $display("FAIL midrst_next_data: got %h expected %h", data, exp_data); end
  endtask

  task automatic test_count_wrap;
    int v0;
    logic [DW-1:0] pl;
    v0 = n_valid;
    for (int it = 0; it < 255; it++) begin
      pl = DW'($urandom());
      send_frame(pl, 8'h00);
      idle(2);
      exp_data = pl; exp_count++;
    end
    idle(4);
    n_assert++; if (n_valid != v0 + 255) begin n_fail++; $display("FAIL wrap_pulses: got %0d expected 255", n_valid - v0); end
    n_assert++; if (fc !== exp_count)    begin n_fail++; $display("FAIL wrap_count: got %0d expected %0d", fc, exp_count); end
    n_assert++; if (data !== exp_data)   begin n_fail++; $display("FAIL wrap_data: got %h expected %h", data, exp_data); end
  endtask

  task automatic test_exclusive_pulses;
    n_assert++; if (both_seen !== 1'b0) begin n_fail++; $display("FAIL pulse_overlap: got %b expected 0", both_seen); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_checksum_error();
    test_sync_in_payload();
    test_timeout();
    test_random_frames();
    test_reset_mid_frame();
    test_count_wrap();
    test_exclusive_pulses();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
